// File: rtl/game_pkg.sv
// Shared game-logic types and constants: LFSR geometry, seed value and the
// random generator state encoding.
package game_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TIME_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  // Feedback taps for x^16+x^14+x^13+x^11+1
  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 13;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } rand_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
  endfunction

endpackage

// File: rtl/rand_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with time-value seeding and a guard
// that keeps the register out of the all-zero lock-up state.
module lfsr16
  import game_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_seed,
  input  logic [TIME_W-1:0] i_time,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] stepped;
  logic [LFSR_W-1:0] seeded;

  always_comb begin
    stepped = lfsr_step(lfsr);
    seeded  = stepped ^ LFSR_W'(i_time);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= LFSR_SEED;
    end else if (i_seed) begin
      lfsr <= (seeded == '0) ? LFSR_SEED : seeded;
    end else begin
      lfsr <= stepped;
    end
  end

  assign o_lfsr = lfsr;

endmodule

// File: rtl/rand_gen.sv
// Uniform random value generator: rejection-samples the LFSR into
// [0, N_CHOICES-1] and offers the result over valid/ready.
// Optional no-repeat filter enabled by RAND_GEN_NO_REPEAT_EN.
module rand_gen
  import game_pkg::*;
#(
  parameter int unsigned N_CHOICES = 6,
  parameter int unsigned OUT_W     = 3,
  parameter int unsigned MAX_DRAW  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [TIME_W-1:0] i_time,
  input  logic              i_seed,
  input  logic              i_req,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_value
);

  localparam int unsigned ATT_W     = (MAX_DRAW > 1) ? $clog2(MAX_DRAW) : 1;
  localparam int unsigned OUT_EXT_W = OUT_W + 1;
  localparam logic [OUT_W:0]     N_EXT    = OUT_EXT_W'(N_CHOICES);
  localparam logic [OUT_W-1:0]   N_TRUNC  = OUT_W'(N_CHOICES);
  localparam logic [ATT_W-1:0]   LAST_ATT = ATT_W'(MAX_DRAW - 1);

  rand_state_t       state;
  rand_state_t       next_state;
  logic [LFSR_W-1:0] lfsr_q;
  logic [ATT_W-1:0]  attempt;
  logic [ATT_W-1:0]  attempt_nxt;
  logic [OUT_W-1:0]  cand;
  logic [OUT_W-1:0]  fold;
  logic [OUT_W-1:0]  pick;
  logic [OUT_W-1:0]  value_nxt;
  logic              in_range;
  logic              accept;
  logic              last_try;
  logic              busy_nxt;
  logic              valid_nxt;
  logic              unused_lfsr_hi;

  lfsr16 u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_seed (i_seed),
    .i_time (i_time),
    .o_lfsr (lfsr_q)
  );

  assign cand           = lfsr_q[OUT_W-1:0];
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:OUT_W];
  assign in_range       = {1'b0, cand} < N_EXT;
  assign last_try       = (attempt == LAST_ATT);

`ifdef RAND_GEN_NO_REPEAT_EN
  logic [OUT_W-1:0] last;
  logic [OUT_W:0]   fold_inc;

  // A repeat-rejected candidate is already in range, so only fold real overflows
  always_comb begin
    fold     = in_range ? cand : cand - N_TRUNC;
    fold_inc = {1'b0, fold} + 1'b1;
    if (fold == last) begin
      pick = (fold_inc == N_EXT) ? '0 : fold_inc[OUT_W-1:0];
    end else begin
      pick = fold;
    end
  end

  assign accept = in_range && (cand != last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last <= '0;
    end else if (state == DRAW && next_state == HOLD) begin
      last <= value_nxt;
    end
  end
`else
  assign fold   = cand - N_TRUNC;
  assign pick   = fold;
  assign accept = in_range;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_req) next_state = DRAW;
      DRAW:    if (accept || last_try) next_state = HOLD;
      HOLD:    if (i_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values for the registered outputs and the attempt counter
  always_comb begin
    attempt_nxt = attempt;
    value_nxt   = o_value;
    busy_nxt    = (next_state != IDLE);
    valid_nxt   = (next_state == HOLD);
    case (state)
      IDLE: if (i_req) attempt_nxt = '0;
      DRAW: begin
        if (accept) begin
          value_nxt = cand;
        end else if (last_try) begin
          value_nxt = pick;
        end else begin
          attempt_nxt = attempt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      attempt <= '0;
      o_value <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      attempt <= attempt_nxt;
      o_value <= value_nxt;
      o_busy  <= busy_nxt;
      o_valid <= valid_nxt;
    end
  end

endmodule
